chaos_map_gen: RTL and testbench
================================

# chaos_map_gen

Logistic-map source that iterates x(n+1) = r·x(n)·(1 − x(n)) in Q8.8 fixed point. It presents each new x on `chaotic_value` with a valid/ready handshake. The block drives the 16-bit Q8.8 input of the comparator (opamp) stage, which slices each value into a chaos bit for the LFSR. It includes degenerate-orbit detection with deterministic reseeding, so the comparator never sees a frozen input.

## Interface
- `SEED_DEFAULT`, 16'h0055: x loaded at reset (only [7:0] used; 0 is replaced by 16'h0001).
- `RESEED_STEP`, 16'h0017: increment added to the seed register on each stuck event.
- `clk`  in  1  rising-edge clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; while high the block keeps iterating.
- `seed_load`  in  1  one-cycle strobe; loads `seed` into x and into the seed register.
- `seed`  in  16  Q8.8 seed; [15:8] ignored; [7:0]==0 is replaced by 16'h0001.
- `r_coef`  in  16  Q8.8 growth rate, unsigned; sampled in MUL1.
- `chaotic_value`  out  16  Q8.8 current x; bits [15:8] are always 0.
- `valid`  out  1  `chaotic_value` holds a new, unconsumed iterate.
- `ready`  in  1  consumer accepts when `valid && ready` at a rising edge.
- `busy`  out  1  high in MUL1/MUL2.
- `stuck_count`  out  8  saturating count of reseed events.

## Operation
- Registers:
  - x (8-bit fraction, x < 1.0).
  - Seed register s (8-bit).
  - p1 (8-bit), holding the MUL1 product.
  - r_q (16-bit), holding the sampled `r_coef`.
- FSM states are IDLE, MUL1, MUL2 and OUT.
- IDLE:
  - If `enable`, go to MUL1.
- MUL1:
  - r_q ← `r_coef`.
  - p1 ← (x · (256 − x)) >> 8, an unsigned 8×9-bit product truncated; max 8'h40.
  - Go to MUL2.
- MUL2:
  - t = (r_q · p1) >> 8, 16×8-bit product truncated.
  - n = 8'hFF if t ≥ 16'h0100, else t[7:0] (saturate below 1.0).
  - Stuck when n == 0 or n == x. Then:
    - s ← s + RESEED_STEP[7:0] (mod 256).
    - n ← that new s, or 8'h01 if the new s is 0.
    - `stuck_count` increments, saturating at 8'hFF.
  - x ← n.
  - `chaotic_value` ← {8'h00, n}.
  - Go to OUT.
- OUT:
  - `valid` = 1.
  - On `ready`:
    - go to MUL1 if `enable`, else IDLE;
    - `valid` drops next cycle.
  - Without `ready`, stay in OUT with `chaotic_value` frozen, regardless of `enable`.
- `seed_load` has the highest priority, in any state. It does all of the following:
  - Aborts the iteration in progress.
  - Loads x and s with `seed[7:0]` (0 → 1).
  - Sends the FSM to IDLE.
  - Clears `valid`.
  - Leaves `chaotic_value` unchanged.
  - Leaves `stuck_count` unchanged.
- `enable` falling in MUL1/MUL2 does not abort. The iterate completes and waits in OUT.
- All arithmetic is unsigned. `r_coef` > 4.0 is legal and is handled by the saturation rule.

## Timing
- Reset values:
  - FSM state IDLE; `valid` = 0; `busy` = 0.
  - `chaotic_value` = 16'h0000; `stuck_count` = 0.
  - x = s = SEED_DEFAULT[7:0], with 0 → 1.
- Latency: `enable` high at edge k in IDLE → MUL1 after k, MUL2 after k+1, OUT with `valid` = 1 after k+2.
- Throughput with `ready` held high is one iterate per 3 cycles. The OUT→MUL1 transition is taken on the accepting edge.
- `valid` only falls after an accepting edge, `seed_load`, or `rst`.
- While `valid && !ready`, `chaotic_value` must not change.
- `rst` overrides `seed_load` when both are asserted in the same cycle.
- `rst` or `seed_load` mid-MUL discards partial products. No `valid` pulse is produced for the aborted iterate.

## Test plan
- Saturation and zero reseed, `RESEED_STEP` = 16'h0017:
  - Stimulus: `seed_load` 16'h0080, `r_coef` 16'h0400, `enable` = 1, `ready` = 1.
  - First output 16'h00FF, at `valid` 3 cycles after IDLE.
  - Second output: n = 0, so reseed to 16'h0097; `stuck_count` = 1.
- Normal orbit:
  - Stimulus: seed 16'h0080, r 16'h0380.
  - Outputs 16'h00E0, then 16'h0062; `stuck_count` stays 0.
- Fixed-point detection:
  - Stimulus: seed 16'h0080, r 16'h0200.
  - Computed 16'h0080 equals x, so the output is 16'h0097 with `stuck_count` = 1.
- Backpressure:
  - Stimulus: hold `ready` = 0 for 10 cycles in OUT.
  - `valid` stays 1 and `chaotic_value` is stable.
  - Release `ready`: `valid` drops, then reasserts 3 cycles later with the next iterate.
- Abort and reset:
  - `seed_load` 16'h0000 asserted in MUL2: x = 16'h0001, FSM goes to IDLE, no `valid` pulse, `stuck_count` unchanged.
  - `rst` in OUT: all outputs return to their reset values on the next cycle.
- Saturating counter:
  - Stimulus: force 300 stuck events (r = 16'h0000).
  - `stuck_count` holds at 8'hFF.
  - Every output is nonzero.

Source files
------------

// File: rtl/chaos_map_gen.sv
// Logistic-map source x' = r*x*(1-x) in Q8.8; three cycles from IDLE to a valid iterate.
// The iterate is held in OUT until consumed; stuck orbits (0 or fixed point) reseed deterministically.
module chaos_map_gen #(
  parameter logic [15:0] SEED_DEFAULT = 16'h0055,
  parameter logic [15:0] RESEED_STEP  = 16'h0017
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic [15:0] r_coef,
  output logic [15:0] chaotic_value,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic [7:0]  stuck_count
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  localparam logic [7:0] SEED_INIT = (SEED_DEFAULT[7:0] == 8'h00) ? 8'h01 : SEED_DEFAULT[7:0];

  state_t      state;
  logic [7:0]  x;
  logic [7:0]  s;
  logic [7:0]  p1;
  logic [15:0] r_q;

  logic [7:0]  seed_x;
  logic [8:0]  one_minus_x;
  logic [16:0] mul1_full;
  logic [23:0] mul2_full;
  logic [15:0] t;
  logic [7:0]  n_raw;
  logic        stuck;
  logic [7:0]  s_bump;
  logic [7:0]  n_fin;
  logic        unused_bits;

  assign seed_x      = (seed[7:0] == 8'h00) ? 8'h01 : seed[7:0];
  assign one_minus_x = 9'd256 - {1'b0, x};
  assign mul1_full   = {9'b0, x} * {8'b0, one_minus_x};
  assign mul2_full   = {8'b0, r_q} * {16'b0, p1};
  assign t           = mul2_full[23:8];
  // Anything at or above 1.0 clamps to the largest representable fraction.
  assign n_raw       = (t >= 16'h0100) ? 8'hFF : t[7:0];
  assign stuck       = (n_raw == 8'h00) || (n_raw == x);
  assign s_bump      = s + RESEED_STEP[7:0];
  assign n_fin       = !stuck ? n_raw : ((s_bump == 8'h00) ? 8'h01 : s_bump);
  assign unused_bits = ^{seed[15:8], mul1_full[16], mul1_full[7:0], mul2_full[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x             <= SEED_INIT;
      s             <= SEED_INIT;
      p1            <= 8'h00;
      r_q           <= 16'h0000;
      chaotic_value <= 16'h0000;
      valid         <= 1'b0;
      busy          <= 1'b0;
      stuck_count   <= 8'h00;
    end else if (seed_load) begin
      state <= IDLE;
      x     <= seed_x;
      s     <= seed_x;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= MUL1;
            busy  <= 1'b1;
          end
        end
        MUL1: begin
          r_q   <= r_coef;
          p1    <= mul1_full[15:8];
          state <= MUL2;
        end
        MUL2: begin
          x             <= n_fin;
          chaotic_value <= {8'h00, n_fin};
          if (stuck) begin
            s <= s_bump;
            if (stuck_count != 8'hFF) stuck_count <= stuck_count + 8'd1;
          end
          state <= OUT;
          busy  <= 1'b0;
          valid <= 1'b1;
        end
        OUT: begin
          if (ready) begin
            valid <= 1'b0;
            if (enable) begin
              state <= MUL1;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_map_gen.sv
// Randomized bench for chaos_map_gen against a plain-arithmetic logistic-map model.
module tb_chaos_map_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed;
  logic [15:0] r_coef;
  logic [15:0] chaotic_value;
  logic        valid;
  logic        ready;
  logic        busy;
  logic [7:0]  stuck_count;

  always #5 clk = ~clk;

  chaos_map_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed(seed),
    .r_coef(r_coef), .chaotic_value(chaotic_value), .valid(valid), .ready(ready),
    .busy(busy), .stuck_count(stuck_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int mx, ms, mcnt;
  int last_val;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_step(input int r);
    int p, tt, n;
    p  = (mx * (256 - mx)) / 256;
    tt = (r * p) / 256;
    n  = (tt > 255) ? 255 : tt;
    if (n == 0 || n == mx) begin
      ms = (ms + 'h17) % 256;
      n  = (ms == 0) ? 1 : ms;
      if (mcnt < 255) mcnt++;
    end
    mx = n;
    return n;
  endfunction

  task automatic model_reset();
    mx = 'h55; ms = 'h55; mcnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_value"}, chaotic_value, 0);
    chk({tag, "_count"}, stuck_count, 0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1; seed_load = 0; enable = 0; ready = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic load(input int sd);
    seed = sd[15:0]; seed_load = 1; enable = 0;
    @(negedge clk);
    seed_load = 0;
    mx = ((sd & 255) == 0) ? 1 : (sd & 255);
    ms = mx;
  endtask

  // Run one iterate: wait for valid, compare, optionally stall, then accept.
  task automatic take(input int r, input int stall, output int l);
    int e;
    r_coef = r[15:0]; enable = 1; ready = 0;
    e = model_step(r);
    l = 0;
    while (!valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    chk("valid_seen", valid, 1);
    chk("value", chaotic_value, e);
    chk("stuck_count", stuck_count, mcnt);
    last_val = chaotic_value;
    for (int i = 0; i < stall; i++) begin
      r_coef = $urandom; enable = $urandom;
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_value", chaotic_value, e);
    end
    enable = 1; ready = 1;
    @(negedge clk);
    ready = 0;
    chk("valid_drop", valid, 0);
  endtask

  initial begin
    rst = 1; enable = 0; seed_load = 0; seed = 0; r_coef = 0; ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    chk_reset_outputs("reset");
    take('h0380, 0, lat);
    chk("lat_idle_default", lat, 3);

    // Saturation then zero-reseed
    do_rst(); load('h0080);
    take('h0400, 0, lat);
    chk("lat_idle", lat, 3);
    chk("sat_first", last_val, 'h00FF);
    take('h0400, 0, lat);
    chk("lat_back2back", lat, 2);
    chk("zero_reseed", last_val, 'h0097);
    chk("zero_reseed_cnt", stuck_count, 1);

    // Normal orbit
    do_rst(); load('h0080);
    take('h0380, 0, lat);
    chk("orbit_1", last_val, 'h00E0);
    take('h0380, 0, lat);
    chk("orbit_2", last_val, 'h0062);
    chk("orbit_cnt", stuck_count, 0);

    // Fixed point
    do_rst(); load('h0080);
    take('h0200, 0, lat);
    chk("fixed_pt", last_val, 'h0097);
    chk("fixed_pt_cnt", stuck_count, 1);

    // Backpressure
    take('h0380, 10, lat);
    take('h0380, 0, lat);
    chk("lat_after_stall", lat, 2);

    // seed_load abort in MUL2
    do_rst(); load('h0080);
    take('h0380, 0, lat);
    r_coef = 'h0380;
    @(negedge clk);
    chk("busy_mul2", busy, 1);
    seed = 16'h0000; seed_load = 1; enable = 0;
    @(negedge clk);
    seed_load = 0;
    mx = 1; ms = 1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_value", chaotic_value, 'h00E0);
    chk("abort_cnt", stuck_count, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_pulse", valid, 0);
    end
    take('h0380, 0, lat);
    chk("abort_lat", lat, 3);
    chk("abort_reseed", last_val, 'h0018);

    // rst in OUT, simultaneous with seed_load
    r_coef = 'h0300; enable = 1; ready = 0;
    lat = 0;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("out_reached", valid, 1);
    rst = 1; seed_load = 1; seed = 'h0033;
    @(negedge clk);
    rst = 0; seed_load = 0; enable = 0;
    model_reset();
    chk_reset_outputs("rst_out");
    take($urandom_range(0, 'h04FF), 0, lat);

    // Saturating counter
    do_rst(); load('h0080);
    for (int i = 0; i < 300; i++) begin
      take(0, 0, lat);
      chk("nonzero", (last_val != 0), 1);
    end
    chk("count_sat", stuck_count, 'hFF);

    // Random walk
    do_rst();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) load($urandom);
      take($urandom_range(0, 'h04FF), $urandom_range(0, 3), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
